array_mult_server: RTL
======================

ARRAY_MULT_SERVER -- requirements
Module: array_mult_server

Interface
REQ-001 Parameter LANES, default 3: physical multiplier lanes.
REQ-002 Parameter FRAC, default 20: fractional bits of the 36-bit signed fixed-point format.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  global enable; low freezes FSM, beat counter and pipeline registers.
REQ-006 req  input  1  request; 9 operand pairs valid this cycle.
REQ-007 array_mult_dataa  input  9x36  operand A per product index 0..8.
REQ-008 array_mult_datab  input  9x36  operand B per product index 0..8.
REQ-009 array_mult_result  output  9x36  product per index, fixed-point, registered.
REQ-010 busy  output  1  high from the cycle after accept through the done cycle.
REQ-011 done  output  1  one-cycle pulse; all 9 results valid.
REQ-012 sat  output  1  high if any product of the last transaction saturated; valid with done, held until next accept.

Function
REQ-013 Accept occurs in cycle T when en=1, req=1 and FSM is IDLE; operands are captured into internal registers at the end of T.
REQ-014 req while busy=1 is ignored, with no effect on the running transaction.
REQ-015 FSM states: IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on accept; ISSUE->DRAIN after beat 2; DRAIN->DONE after one cycle; DONE->IDLE unconditionally.
REQ-016 ISSUE lasts 3 enabled cycles (beats 0,1,2 at T+1..T+3); beat k multiplies indices 3k..3k+2 on lanes 0..2.
REQ-017 Pipeline stage 1 registers the full 72-bit signed product at the end of the issue cycle.
REQ-018 Stage 2 adds 2^(FRAC-1), arithmetic-shifts right by FRAC, saturates to [-2^35, 2^35-1] and writes array_mult_result[idx] one cycle later.
REQ-019 Last result is written at end of T+4 (DRAIN); done=1 and busy=1 in T+5 (DONE); back-to-back accept is allowed at T+6 earliest.
REQ-020 With en held high, latency accept-to-done is exactly 5 cycles; every en=0 cycle adds exactly one cycle.
REQ-021 sat clears on accept and sets sticky when any stage-2 saturation occurs in the transaction.
REQ-022 array_mult_result entries hold their values between transactions and change only on stage-2 writes.
REQ-023 req with en=0 is not accepted.

Reset
REQ-024 rst low clears immediately: FSM to IDLE, beat counter 0, pipeline registers 0, array_mult_result all 0, busy 0, done 0, sat 0.
REQ-025 rst asserted mid-transaction aborts it; no done pulse is produced for that transaction.
REQ-026 First accept is possible in the first enabled cycle after rst deasserts.

Structure
REQ-027 Shared package holds the fixed-point width (36), FRAC, the number of products (9) and the FSM state enum.
REQ-028 One sub-module, fxp_mult_lane: 2-stage signed multiply plus round/saturate with a sat flag; instantiated LANES times.
REQ-029 Stage-1 index tags travel with the data; no combinational path from inputs to outputs.

Verification
REQ-030 a[i]=0x000100000 (1.0), b[i]=0x000280000 (2.5), all i -> every result 0x000280000, sat=0, done exactly at T+5.
REQ-031 a[4]=0xFFFE80000 (-1.5), b[4]=0x000200000 (2.0) -> result[4]=0xFFFD00000, other indices per their operands.
REQ-032 Rounding: a[0]=0x000000001, b[0]=0x000080000 -> result[0]=0x000000001; a[1]=0x000000001, b[1]=0x00007FFFF -> result[1]=0.
REQ-033 a[8]=b[8]=0x7FFFFFFFF -> result[8]=0x7FFFFFFFF, sat=1; a[8]=0x800000000, b[8]=0x7FFFFFFFF -> 0x800000000, sat=1.
REQ-034 en low for 2 cycles during beat 1, plus req pulses while busy -> done at T+7, results correct, the extra reqs ignored.
REQ-035 rst pulsed low at T+3 -> outputs 0 immediately, no done pulse; a new req after release completes normally with done at its own T+5.

Source files
------------

// File: rtl/array_mult_server_pkg.sv
// -----------------------------------------------------------------------------
// array_mult_server_pkg
// Shared constants and types for the array multiply server.
//   FXW          : width of one signed fixed-point operand/result (36 bits)
//   FRAC_DEFAULT : default number of fractional bits in that format
//   NPROD        : number of operand pairs / products per transaction
//   TAGW         : width of a product index tag
//   state_e      : FSM state encoding of the server
// -----------------------------------------------------------------------------
package array_mult_server_pkg;

    localparam int FXW          = 36;
    localparam int FRAC_DEFAULT = 20;
    localparam int NPROD        = 9;
    localparam int TAGW         = $clog2(NPROD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/array_mult_server_fxp_mult_lane.sv
// -----------------------------------------------------------------------------
// fxp_mult_lane
// One signed fixed-point multiplier lane.
//   Stage 1 (registered): full 2*FXW-bit signed product plus index tag/valid.
//   Stage 2 (combinational from stage 1): round-half-up by adding
//   2^(FRAC-1), arithmetic shift right by FRAC, saturate to the FXW-bit range.
//   The consumer registers the stage-2 outputs, so a product is stored one
//   cycle after its stage-1 register is loaded.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                global enable; low freezes the stage-1 registers
//   in_valid, in_tag  issue strobe and product index for in_a/in_b
//   in_a, in_b        signed operands
//   out_valid/out_tag stage-2 strobe and index (travel with the data)
//   out_data, out_sat rounded/saturated result and saturation flag
// -----------------------------------------------------------------------------
module fxp_mult_lane #(
    parameter int FXW  = 36,
    parameter int FRAC = 20,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            in_valid,
    input  logic [TAGW-1:0] in_tag,
    input  logic [FXW-1:0]  in_a,
    input  logic [FXW-1:0]  in_b,
    output logic            out_valid,
    output logic [TAGW-1:0] out_tag,
    output logic [FXW-1:0]  out_data,
    output logic            out_sat
);

    localparam int PW = 2 * FXW;

    // Rounding constant and saturation bounds, one bit wider than the product
    // so the rounding add cannot overflow.
    localparam logic signed [PW:0] RND  = {{(PW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [PW:0] MAXV = {{(PW-FXW+2){1'b0}}, {(FXW-1){1'b1}}};
    localparam logic signed [PW:0] MINV = {{(PW-FXW+2){1'b1}}, {(FXW-1){1'b0}}};

    logic signed [PW-1:0] prod_q, prod_d;
    logic                 vld_q, vld_d;
    logic [TAGW-1:0]      tag_q, tag_d;

    logic signed [PW-1:0] a_ext, b_ext;
    logic signed [PW:0]   rounded, shifted;
    logic                 ovf;

    always_comb begin
        a_ext  = {{FXW{in_a[FXW-1]}}, in_a};
        b_ext  = {{FXW{in_b[FXW-1]}}, in_b};
        prod_d = prod_q;
        vld_d  = vld_q;
        tag_d  = tag_q;
        if (en) begin
            vld_d = in_valid;
            tag_d = in_tag;
            if (in_valid) begin
                prod_d = a_ext * b_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            tag_q  <= '0;
        end else begin
            prod_q <= prod_d;
            vld_q  <= vld_d;
            tag_q  <= tag_d;
        end
    end

    always_comb begin
        rounded  = $signed({prod_q[PW-1], prod_q}) + RND;
        shifted  = rounded >>> FRAC;
        ovf      = 1'b0;
        out_data = shifted[FXW-1:0];
        if (shifted > MAXV) begin
            out_data = MAXV[FXW-1:0];
            ovf      = 1'b1;
        end else if (shifted < MINV) begin
            out_data = MINV[FXW-1:0];
            ovf      = 1'b1;
        end
        out_valid = vld_q;
        out_tag   = tag_q;
        out_sat   = vld_q & ovf;
    end

endmodule

// File: rtl/array_mult_server.sv
// -----------------------------------------------------------------------------
// array_mult_server
// Multiplies NPROD signed fixed-point operand pairs per transaction using
// LANES shared multiplier lanes, LANES products per beat.
// Handshake: a request is taken in any cycle with en=1, req=1 and the server
// idle (busy=0); operands are captured at the end of that cycle. busy stays
// high from the next cycle through the done cycle and any req seen while busy
// is ignored. done pulses for one cycle once every result is stored; sat is
// valid with done and held until the next accept.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   en                            global enable (freezes FSM and pipeline)
//   req                           request strobe
//   array_mult_dataa/_datab       NPROD packed operands, index i at [i*FXW +: FXW]
//   array_mult_result             NPROD packed registered results
//   busy, done, sat               status
//   dbg_state                     current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module array_mult_server
    import array_mult_server_pkg::*;
#(
    parameter int LANES = 3,
    parameter int FRAC  = FRAC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 req,
    input  logic [NPROD*FXW-1:0] array_mult_dataa,
    input  logic [NPROD*FXW-1:0] array_mult_datab,
    output logic [NPROD*FXW-1:0] array_mult_result,
    output logic                 busy,
    output logic                 done,
    output logic                 sat,
    output logic [1:0]           dbg_state
);

    localparam int NBEATS = (NPROD + LANES - 1) / LANES;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [FXW-1:0]  opa_q [NPROD];
    logic [FXW-1:0]  opa_d [NPROD];
    logic [FXW-1:0]  opb_q [NPROD];
    logic [FXW-1:0]  opb_d [NPROD];
    logic [FXW-1:0]  res_q [NPROD];
    logic [FXW-1:0]  res_d [NPROD];
    logic            sat_q, sat_d;
    logic            accept;

    logic            lane_in_valid  [LANES];
    logic [TAGW-1:0] lane_in_tag    [LANES];
    logic [FXW-1:0]  lane_in_a      [LANES];
    logic [FXW-1:0]  lane_in_b      [LANES];
    logic            lane_out_valid [LANES];
    logic [TAGW-1:0] lane_out_tag   [LANES];
    logic [FXW-1:0]  lane_out_data  [LANES];
    logic            lane_out_sat   [LANES];

    // Control FSM, beat counter and operand capture.
    always_comb begin
        accept  = en && req && (state_q == ST_IDLE);
        state_d = state_q;
        beat_d  = beat_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        if (accept) begin
            for (int i = 0; i < NPROD; i++) begin
                opa_d[i] = array_mult_dataa[i*FXW +: FXW];
                opb_d[i] = array_mult_datab[i*FXW +: FXW];
            end
        end
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_ISSUE;
                        beat_d  = '0;
                    end
                end
                ST_ISSUE: begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_DRAIN;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                ST_DRAIN: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Beat k feeds products k*LANES .. k*LANES+LANES-1; lanes past the last
    // product in a partial final beat stay idle.
    always_comb begin : lane_feed
        int idx;
        for (int l = 0; l < LANES; l++) begin
            idx               = int'(beat_q) * LANES + l;
            lane_in_valid[l]  = (state_q == ST_ISSUE) && (idx < NPROD);
            lane_in_tag[l]    = TAGW'(idx);
            lane_in_a[l]      = '0;
            lane_in_b[l]      = '0;
            if (lane_in_valid[l]) begin
                lane_in_a[l] = opa_q[lane_in_tag[l]];
                lane_in_b[l] = opb_q[lane_in_tag[l]];
            end
        end
    end

    // Stage-2 writeback into the result registers, plus the sticky sat flag.
    always_comb begin
        res_d = res_q;
        sat_d = sat_q;
        if (accept) begin
            sat_d = 1'b0;
        end
        if (en) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_out_valid[l]) begin
                    res_d[lane_out_tag[l]] = lane_out_data[l];
                    if (lane_out_sat[l]) begin
                        sat_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            sat_q   <= 1'b0;
            for (int i = 0; i < NPROD; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            sat_q   <= sat_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fxp_mult_lane #(
            .FXW  (FXW),
            .FRAC (FRAC),
            .TAGW (TAGW)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst),
            .en        (en),
            .in_valid  (lane_in_valid[l]),
            .in_tag    (lane_in_tag[l]),
            .in_a      (lane_in_a[l]),
            .in_b      (lane_in_b[l]),
            .out_valid (lane_out_valid[l]),
            .out_tag   (lane_out_tag[l]),
            .out_data  (lane_out_data[l]),
            .out_sat   (lane_out_sat[l])
        );
    end

    for (genvar i = 0; i < NPROD; i++) begin : g_res
        assign array_mult_result[i*FXW +: FXW] = res_q[i];
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign sat       = sat_q;
    assign dbg_state = state_q;

endmodule
